kb_ps2_ctrl: RTL and testbench

//  PS/2 host-side controller between the ps2 rx/tx byte engines and the scan-code decoder (keyboard).

---
 rtl/kb_ps2_pkg.sv | 36 +++
 rtl/kb_ps2_ctrl_if.sv | 27 ++
 rtl/kb_ps2_timer.sv | 20 ++
 rtl/kb_ps2_ctrl.sv | 110 +++++++++++
 tb/tb_kb_ps2_ctrl.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/kb_ps2_pkg.sv
// kb_ps2_pkg: PS/2 keyboard command/response bytes, controller state encoding and state-mapping helpers.
package kb_ps2_pkg;
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_SET_LED  = 8'hED;
    localparam logic [7:0] RSP_ACK      = 8'hFA;
    localparam logic [7:0] RSP_RESEND   = 8'hFE;
    localparam logic [7:0] RSP_BAT_OK   = 8'hAA;
    localparam logic [7:0] RSP_BAT_ERR0 = 8'hFC;
    localparam logic [7:0] RSP_BAT_ERR1 = 8'hFD;

    typedef enum logic [3:0] {
        ST_INIT_WAIT,
        ST_TX_RST,
        ST_ACK_RST,
        ST_BAT,
        ST_RUN,
        ST_TX_LEDCMD,
        ST_ACK_LEDCMD,
        ST_TX_LEDVAL,
        ST_ACK_LEDVAL,
        ST_FAIL
    } state_t;

    function automatic state_t ack_of(state_t s);
        return s == ST_TX_RST ? ST_ACK_RST : s == ST_TX_LEDCMD ? ST_ACK_LEDCMD : ST_ACK_LEDVAL;
    endfunction

    // Resend target for a failed response; BAT timeouts restart from the reset command.
    function automatic state_t tx_of(state_t s);
        return s == ST_ACK_LEDCMD ? ST_TX_LEDCMD : s == ST_ACK_LEDVAL ? ST_TX_LEDVAL : ST_TX_RST;
    endfunction

    function automatic state_t ack_next(state_t s);
        return s == ST_ACK_RST ? ST_BAT : s == ST_ACK_LEDCMD ? ST_TX_LEDVAL : ST_RUN;
    endfunction
endpackage

// File: rtl/kb_ps2_ctrl_if.sv
// kb_ps2_ctrl_if: signals between the PS/2 host controller and the rx/tx engines, decoder and game logic.
interface kb_ps2_ctrl_if;
    logic       rx_done_tick;
    logic [7:0] rx_dout;
    logic       tx_idle;
    logic       tx_done_tick;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       rx_en;
    logic       scan_done_tick;
    logic [7:0] scan_dout;
    logic       led_req;
    logic [2:0] led_val;
    logic       led_ack;
    logic       ready;
    logic       error;

    modport master (
        input  rx_done_tick, rx_dout, tx_idle, tx_done_tick, led_req, led_val,
        output tx_start, tx_data, rx_en, scan_done_tick, scan_dout, led_ack, ready, error
    );

    modport slave (
        output rx_done_tick, rx_dout, tx_idle, tx_done_tick, led_req, led_val,
        input  tx_start, tx_data, rx_en, scan_done_tick, scan_dout, led_ack, ready, error
    );
endinterface

// File: rtl/kb_ps2_timer.sv
// kb_ps2_timer: loadable down-counter that stops at zero and flags expiry there.
module kb_ps2_timer #(
    parameter int unsigned     W       = 8,
    parameter logic [W-1:0]    RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);
    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge reset)
        if (!reset) cnt <= RST_VAL;
        else if (load) cnt <= load_val;
        else if (cnt != '0) cnt <= cnt - W'(1);

    assign expired = cnt == '0;
endmodule

// File: rtl/kb_ps2_ctrl.sv
// kb_ps2_ctrl: PS/2 host controller sequencing keyboard init, LED updates and scan-byte forwarding.
module kb_ps2_ctrl
    import kb_ps2_pkg::*;
#(
    parameter int INIT_WAIT_CYC = 500_000,
    parameter int RESP_TIMEOUT  = 1_000_000,
    parameter int MAX_RETRY     = 3
) (
    input logic           clk,
    input logic           reset,
    kb_ps2_ctrl_if.master bus
);
    localparam int TMAX = INIT_WAIT_CYC > RESP_TIMEOUT ? INIT_WAIT_CYC : RESP_TIMEOUT;
    localparam int TW   = $clog2(TMAX + 1);

    state_t     state;
    logic       sent;
    logic [2:0] retry;
    logic [7:0] led_byte, tx_byte;
    logic       tx_st, tx_fin, rsp_ack, rsp_rsnd, rsp_bat_err, fwd, exhausted, tmr_load, expired;

    always_comb begin
        tx_st       = state inside {ST_TX_RST, ST_TX_LEDCMD, ST_TX_LEDVAL};
        tx_fin      = tx_st && sent && bus.tx_done_tick;
        rsp_ack     = bus.rx_done_tick && bus.rx_dout == RSP_ACK;
        rsp_rsnd    = bus.rx_done_tick && bus.rx_dout == RSP_RESEND;
        rsp_bat_err = bus.rx_done_tick && (bus.rx_dout == RSP_BAT_ERR0 || bus.rx_dout == RSP_BAT_ERR1);
        fwd         = state == ST_RUN || state == ST_FAIL;
        exhausted   = retry == 3'(MAX_RETRY);
        tmr_load    = tx_fin || (state == ST_ACK_RST && rsp_ack);
        tx_byte     = state == ST_TX_RST ? CMD_RESET : state == ST_TX_LEDCMD ? CMD_SET_LED : led_byte;
    end

    kb_ps2_timer #(.W(TW), .RST_VAL(TW'(INIT_WAIT_CYC))) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (TW'(RESP_TIMEOUT)),
        .expired  (expired)
    );

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state              <= ST_INIT_WAIT;
            sent               <= 1'b0;
            retry              <= '0;
            led_byte           <= '0;
            bus.tx_start       <= 1'b0;
            bus.tx_data        <= '0;
            bus.rx_en          <= 1'b0;
            bus.scan_done_tick <= 1'b0;
            bus.scan_dout      <= '0;
            bus.led_ack        <= 1'b0;
            bus.ready          <= 1'b0;
            bus.error          <= 1'b0;
        end else begin
            bus.tx_start       <= 1'b0;
            bus.led_ack        <= 1'b0;
            bus.scan_done_tick <= fwd && bus.rx_done_tick;
            if (fwd && bus.rx_done_tick) bus.scan_dout <= bus.rx_dout;
            case (state)
                ST_INIT_WAIT: if (expired) state <= ST_TX_RST;
                ST_TX_RST, ST_TX_LEDCMD, ST_TX_LEDVAL:
                    if (!sent && bus.tx_idle) begin
                        bus.tx_start <= 1'b1;
                        bus.tx_data  <= tx_byte;
                        bus.rx_en    <= 1'b0;
                        sent         <= 1'b1;
                    end else if (tx_fin) begin
                        bus.rx_en <= 1'b1;
                        sent      <= 1'b0;
                        state     <= ack_of(state);
                    end
                ST_ACK_RST, ST_ACK_LEDCMD, ST_ACK_LEDVAL:
                    if (rsp_ack) begin
                        retry       <= '0;
                        state       <= ack_next(state);
                        bus.led_ack <= state == ST_ACK_LEDVAL;
                        bus.ready   <= state == ST_ACK_LEDVAL;
                    end else if (rsp_rsnd || expired) begin
                        // an abandoned LED exchange still owes its requester an ack
                        retry       <= retry + 3'd1;
                        state       <= exhausted ? ST_FAIL : tx_of(state);
                        bus.error   <= exhausted;
                        bus.led_ack <= exhausted && state != ST_ACK_RST;
                    end
                ST_BAT:
                    if (bus.rx_done_tick && bus.rx_dout == RSP_BAT_OK) begin
                        retry     <= '0;
                        state     <= ST_RUN;
                        bus.ready <= 1'b1;
                    end else if (rsp_bat_err) begin
                        state     <= ST_FAIL;
                        bus.error <= 1'b1;
                    end else if (expired) begin
                        retry     <= retry + 3'd1;
                        state     <= exhausted ? ST_FAIL : ST_TX_RST;
                        bus.error <= exhausted;
                    end
                ST_RUN:
                    if (bus.led_req && !bus.led_ack) begin
                        led_byte  <= {5'b0, bus.led_val};
                        state     <= ST_TX_LEDCMD;
                        bus.ready <= 1'b0;
                    end
                ST_FAIL: if (bus.led_req && !bus.led_ack) bus.led_ack <= 1'b1;
                default: state <= ST_INIT_WAIT;
            endcase
        end
endmodule

// File: tb/tb_kb_ps2_ctrl.sv
// tb_kb_ps2_ctrl: directed + randomized checks of kb_ps2_ctrl against a keyboard/tx-engine model and scoreboards.
module tb_kb_ps2_ctrl;
    import kb_ps2_pkg::*;
    localparam int INIT = 100, RESP = 200, MAXR = 3, TX_LAT = 4;

    logic clk = 1'b0, reset = 1'b0;
    int   checks = 0, errors = 0, cyc = 0, ack_cnt = 0, rst_tx = 0;
    bit   tx_busy = 1'b0;
    logic [7:0] tx_q[$], exp_q[$], got_q[$];
    int         tx_cyc_q[$];

    kb_ps2_ctrl_if bus();
    kb_ps2_ctrl #(.INIT_WAIT_CYC(INIT), .RESP_TIMEOUT(RESP), .MAX_RETRY(MAXR)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.tx_start) begin
            tx_q.push_back(bus.tx_data);
            tx_cyc_q.push_back(cyc);
        end
        if (bus.scan_done_tick) got_q.push_back(bus.scan_dout);
        if (bus.led_ack) ack_cnt++;
        if (!reset && bus.tx_start) rst_tx++;
    end

    // tx engine: busy for TX_LAT cycles after each tx_start, then a done pulse
    initial begin
        bus.tx_idle      = 1'b1;
        bus.tx_done_tick = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.tx_start) begin
                tx_busy     = 1'b1;
                bus.tx_idle = 1'b0;
                repeat (TX_LAT) @(negedge clk);
                bus.tx_done_tick = 1'b1;
                @(negedge clk);
                bus.tx_done_tick = 1'b0;
                bus.tx_idle      = 1'b1;
                tx_busy          = 1'b0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_rx(logic [7:0] b, bit fwd);
        bus.rx_dout      = b;
        bus.rx_done_tick = 1'b1;
        tick();
        bus.rx_done_tick = 1'b0;
        bus.rx_dout      = 8'($urandom);
        chk("scan_tick", 32'(bus.scan_done_tick), 32'(fwd));
        if (fwd) begin
            chk("scan_data", 32'(bus.scan_dout), 32'(b));
            exp_q.push_back(b);
        end
    endtask

    task automatic wait_tx(string tag, logic [7:0] b, output int tc);
        tc = -1;
        for (int i = 0; i < 2 * RESP + INIT && tx_q.size() == 0; i++) tick();
        chk({tag, "_count"}, 32'(tx_q.size()), 32'd1);
        if (tx_q.size() > 0) begin
            chk(tag, 32'(tx_q.pop_front()), 32'(b));
            tc = tx_cyc_q.pop_front();
        end
    endtask

    task automatic wait_done();
        for (int i = 0; i < 50 && tx_busy; i++) tick();
        chk("tx_done_wait", 32'(tx_busy), 32'd0);
        tick();
    endtask

    task automatic cmp_scan(string tag);
        tick();
        chk({tag, "_cnt"}, 32'(got_q.size()), 32'(exp_q.size()));
        while (got_q.size() > 0 && exp_q.size() > 0) chk(tag, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_ready"}, 32'(bus.ready), 32'd0);
        chk({tag, "_error"}, 32'(bus.error), 32'd0);
        chk({tag, "_rx_en"}, 32'(bus.rx_en), 32'd0);
        chk({tag, "_tx_start"}, 32'(bus.tx_start), 32'd0);
        chk({tag, "_tx_data"}, 32'(bus.tx_data), 32'd0);
        chk({tag, "_led_ack"}, 32'(bus.led_ack), 32'd0);
        chk({tag, "_scan_tick"}, 32'(bus.scan_done_tick), 32'd0);
    endtask

    initial begin
        int tc, tp, nc, nv, a0;
        logic [2:0] v;
        logic [7:0] b;
        bus.rx_done_tick = 1'b0;
        bus.rx_dout      = '0;
        bus.led_req      = 1'b0;
        bus.led_val      = '0;
        tick(3);
        chk_zero("reset");
        reset = 1'b1;
        tp = cyc;
        tick(10);
        chk("rx_en_init", 32'(bus.rx_en), 32'd0);
        send_rx(8'h1C, 1'b0);
        // init: FF, ACK, BAT
        wait_tx("tx_rst", CMD_RESET, tc);
        chk("init_wait", 32'(tc - tp >= INIT), 32'd1);
        chk("rx_en_tx", 32'(bus.rx_en), 32'd0);
        wait_done();
        chk("rx_en_ack", 32'(bus.rx_en), 32'd1);
        send_rx(RSP_ACK, 1'b0);
        send_rx(RSP_BAT_OK, 1'b0);
        chk("ready_run", 32'(bus.ready), 32'd1);
        chk("error_run", 32'(bus.error), 32'd0);
        chk("rx_en_run", 32'(bus.rx_en), 32'd1);
        // scan forwarding in RUN
        send_rx(8'h1C, 1'b1);
        send_rx(8'hF0, 1'b1);
        send_rx(8'h1C, 1'b1);
        repeat (20) begin
            tick($urandom_range(0, 3));
            send_rx(8'($urandom), 1'b1);
        end
        cmp_scan("scan_run");
        // LED updates with randomized resend counts
        for (int r = 0; r < 4; r++) begin
            v  = r == 0 ? 3'b101 : 3'($urandom);
            nc = r == 0 ? 1 : $urandom_range(0, 2);
            nv = $urandom_range(0, 2);
            a0 = ack_cnt;
            bus.led_val = v;
            bus.led_req = 1'b1;
            tick();
            bus.led_val = ~v;
            chk("ready_led_busy", 32'(bus.ready), 32'd0);
            for (int k = 0; k <= nc; k++) begin
                wait_tx("tx_ledcmd", CMD_SET_LED, tc);
                wait_done();
                if (k == 0) send_rx(8'h55, 1'b0);
                send_rx(k < nc ? RSP_RESEND : RSP_ACK, 1'b0);
            end
            for (int k = 0; k <= nv; k++) begin
                wait_tx("tx_ledval", {5'b0, v}, tc);
                wait_done();
                send_rx(k < nv ? RSP_RESEND : RSP_ACK, 1'b0);
            end
            chk("led_ack", 32'(bus.led_ack), 32'd1);
            chk("ready_after_led", 32'(bus.ready), 32'd1);
            bus.led_req = 1'b0;
            tick();
            chk("led_ack_pulse", 32'(bus.led_ack), 32'd0);
            chk("led_ack_count", 32'(ack_cnt - a0), 32'd1);
            send_rx(8'($urandom), 1'b1);
        end
        chk("no_extra_tx", 32'(tx_q.size()), 32'd0);
        cmp_scan("scan_led");
        // reset while the value byte is still shifting out
        v = 3'($urandom);
        bus.led_val = v;
        bus.led_req = 1'b1;
        tick();
        wait_tx("tx_ledcmd_r", CMD_SET_LED, tc);
        wait_done();
        send_rx(RSP_ACK, 1'b0);
        wait_tx("tx_ledval_r", {5'b0, v}, tc);
        chk("tx_busy_at_reset", 32'(bus.tx_idle), 32'd0);
        reset = 1'b0;
        bus.led_req = 1'b0;
        #1;
        chk_zero("mid_reset");
        a0 = ack_cnt;
        tick(8);
        reset = 1'b1;
        tp = cyc;
        send_rx(8'hAB, 1'b0);
        // keyboard silent: MAXR+1 reset commands, then FAIL
        wait_tx("tx_rst2", CMD_RESET, tc);
        chk("init_wait2", 32'(tc - tp >= INIT), 32'd1);
        for (int k = 0; k < MAXR; k++) begin
            tp = tc;
            wait_tx("tx_rst_retry", CMD_RESET, tc);
            chk("retry_spacing", 32'(tc - tp >= RESP && tc - tp <= RESP + TX_LAT + 12), 32'd1);
        end
        for (int i = 0; i < RESP + 50 && !bus.error; i++) tick();
        chk("error_timeout", 32'(bus.error), 32'd1);
        chk("ready_fail", 32'(bus.ready), 32'd0);
        chk("rx_en_fail", 32'(bus.rx_en), 32'd1);
        tick(RESP + 20);
        chk("no_fifth_tx", 32'(tx_q.size()), 32'd0);
        chk("no_ack_after_reset", 32'(ack_cnt - a0), 32'd0);
        repeat (5) send_rx(8'($urandom), 1'b1);
        bus.led_val = 3'($urandom);
        bus.led_req = 1'b1;
        tick();
        chk("fail_led_ack", 32'(bus.led_ack), 32'd1);
        bus.led_req = 1'b0;
        tick();
        chk("fail_led_ack_pulse", 32'(bus.led_ack), 32'd0);
        chk("fail_no_tx", 32'(tx_q.size()), 32'd0);
        cmp_scan("scan_fail");
        // MAXR resends still recover; then a bad BAT code
        reset = 1'b0;
        tick(2);
        reset = 1'b1;
        for (int k = 0; k <= MAXR; k++) begin
            wait_tx("tx_rst3", CMD_RESET, tc);
            wait_done();
            send_rx(k < MAXR ? RSP_RESEND : RSP_ACK, 1'b0);
        end
        chk("error_before_bat", 32'(bus.error), 32'd0);
        b = $urandom_range(0, 1) == 0 ? RSP_BAT_ERR0 : RSP_BAT_ERR1;
        send_rx(b, 1'b0);
        chk("error_bat", 32'(bus.error), 32'd1);
        chk("ready_bat", 32'(bus.ready), 32'd0);
        bus.led_req = 1'b1;
        tick();
        chk("bat_led_ack", 32'(bus.led_ack), 32'd1);
        bus.led_req = 1'b0;
        tick(5);
        chk("bat_no_tx", 32'(tx_q.size()), 32'd0);
        chk("tx_in_reset", 32'(rst_tx), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
